// File: rtl/dl_reset_sequencer.sv
// dl_reset_sequencer
// Turns the hps_io ioctl download stream into per-region ROM write strobes
// and captures the DIP switch bytes. Holds mario_top in reset until a
// complete, in-order ROM image has landed, and then for a settling delay.
//
// Ports
//   clk_sys, reset        system clock, async active-high block reset
//   ioctl_*               hps_io download bus (download, wr, addr, dout, index)
//   user_reset            OSD/button reset level
//   dn_wr/rgn/addr/data   registered ROM write: region and offset within it
//   dip0, dip1            captured DIP bytes
//   core_reset_n          active-low reset to mario_top
//   rom_ok, load_err      result of the most recent ROM load
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no valid ROM image, core held in reset
// S_LOAD | ROM download in progress, writes forwarded, order tracked
// S_HOLD | good image present, core held while hold_cnt counts down
// S_RUN  | core released
module dl_reset_sequencer #(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [7:0]  DIP_INDEX   = 8'd254,
    parameter logic [24:0] RGN1_BASE   = 25'h0F000,
    parameter logic [24:0] RGN2_BASE   = 25'h10000,
    parameter logic [24:0] RGN3_BASE   = 25'h12000,
    parameter logic [24:0] RGN_END     = 25'h1A200,
    parameter logic [15:0] HOLD_CYCLES = 16'd1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic        user_reset,
    output logic        dn_wr,
    output logic [1:0]  dn_rgn,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic [7:0]  dip0,
    output logic [7:0]  dip1,
    output logic        core_reset_n,
    output logic        rom_ok,
    output logic        load_err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

    state_t      state_q, state_d;
    logic        dl_q;
    logic [24:0] byte_cnt_q, byte_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        rom_ok_q, rom_ok_d;
    logic        load_err_q, load_err_d;

    logic        rom_sel, dl_rise, dl_fall, rom_wr, dip_wr;
    logic [1:0]  rgn_sel;
    logic [24:0] rgn_base;
    logic [15:0] rgn_ofs;

    assign rom_sel = (ioctl_index == ROM_INDEX);
    assign dl_rise = ioctl_download & ~dl_q & rom_sel;
    assign dl_fall = ~ioctl_download & dl_q;
    assign rom_wr  = (state_q == S_LOAD) & ioctl_wr & rom_sel & (ioctl_addr < RGN_END);
    assign dip_wr  = ioctl_wr & (ioctl_index == DIP_INDEX) & (ioctl_addr[24:1] == 24'd0);

    always_comb begin
        rgn_sel  = 2'd0;
        rgn_base = 25'd0;
        if (ioctl_addr >= RGN3_BASE) begin
            rgn_sel  = 2'd3;
            rgn_base = RGN3_BASE;
        end else if (ioctl_addr >= RGN2_BASE) begin
            rgn_sel  = 2'd2;
            rgn_base = RGN2_BASE;
        end else if (ioctl_addr >= RGN1_BASE) begin
            rgn_sel  = 2'd1;
            rgn_base = RGN1_BASE;
        end
    end

    assign rgn_ofs = 16'(ioctl_addr - rgn_base);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rom_ok_d   = rom_ok_q;
        load_err_d = load_err_q;
        if (dl_rise) begin
            // a new ROM load pre-empts everything, including user_reset
            state_d    = S_LOAD;
            byte_cnt_d = 25'd0;
            rom_ok_d   = 1'b0;
            load_err_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (dl_fall) begin
                        if (byte_cnt_q == RGN_END && !load_err_q) begin
                            rom_ok_d   = 1'b1;
                            hold_cnt_d = HOLD_CYCLES;
                            state_d    = S_HOLD;
                        end else begin
                            load_err_d = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end else if (rom_wr) begin
                        // out-of-order bytes are still forwarded, only flagged
                        if (ioctl_addr == byte_cnt_q)
                            byte_cnt_d = byte_cnt_q + 25'd1;
                        else
                            load_err_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (user_reset)
                        hold_cnt_d = HOLD_CYCLES;
                    else if (hold_cnt_q == 16'd0)
                        state_d = S_RUN;
                    else
                        hold_cnt_d = hold_cnt_q - 16'd1;
                end
                S_RUN: begin
                    if (user_reset) begin
                        hold_cnt_d = HOLD_CYCLES;
                        state_d    = S_HOLD;
                    end
                end
                default: ;
            endcase
        end
    end

    // dl_q resets high so a download already in flight when reset drops
    // is not mistaken for a fresh load start.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dl_q       <= 1'b1;
            byte_cnt_q <= 25'd0;
            hold_cnt_q <= 16'd0;
            rom_ok_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl_download;
            byte_cnt_q <= byte_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rom_ok_q   <= rom_ok_d;
            load_err_q <= load_err_d;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dn_wr   <= 1'b0;
            dn_rgn  <= 2'd0;
            dn_addr <= 16'd0;
            dn_data <= 8'd0;
        end else begin
            dn_wr <= rom_wr;
            if (rom_wr) begin
                dn_rgn  <= rgn_sel;
                dn_addr <= rgn_ofs;
                dn_data <= ioctl_dout;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dip0 <= 8'hFF;
            dip1 <= 8'hFF;
        end else if (dip_wr) begin
            if (ioctl_addr[0])
                dip1 <= ioctl_dout;
            else
                dip0 <= ioctl_dout;
        end
    end

    assign core_reset_n = (state_q == S_RUN);
    assign rom_ok       = rom_ok_q;
    assign load_err     = load_err_q;

endmodule

// File: doc/dl_reset_sequencer.md
# dl_reset_sequencer

Sequences ROM download and core reset for the Mario Bros core. Sits between the `hps_io` ioctl bus and `mario_top`. It decodes the download stream into per-region ROM write strobes and captures DIP-switch bytes. It holds the core in reset during and after a ROM load, and only releases it after a complete, in-order image has landed plus a settling delay.

## Interface
Parameters:
- `ROM_INDEX`, 8'd0: ioctl_index value for the ROM image.
- `DIP_INDEX`, 8'd254: ioctl_index value for the DIP bytes.
- `RGN1_BASE`, 25'h0F000: start of region 1 (sound CPU ROM). Region 0 (main CPU) starts at 0.
- `RGN2_BASE`, 25'h10000: start of region 2 (tile ROMs).
- `RGN3_BASE`, 25'h12000: start of region 3 (sprite ROMs / PROMs).
- `RGN_END`, 25'h1A200: image length in bytes. Addresses at or above this value are ignored.
- `HOLD_CYCLES`, 16'd1024: clk_sys cycles of reset held after a good load or a user reset.

Ports:
- `clk_sys`  in  1  system clock (24 MHz).
- `reset`  in  1  asynchronous, active-high block reset.
- `ioctl_download`  in  1  download active.
- `ioctl_wr`  in  1  single-cycle byte strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_dout`  in  8  byte data.
- `ioctl_index`  in  8  download target.
- `user_reset`  in  1  level; OSD reset or button reset.
- `dn_wr`  out  1  registered ROM write pulse.
- `dn_rgn`  out  2  region of the current write.
- `dn_addr`  out  16  offset within the region (addr − region base).
- `dn_data`  out  8  write data.
- `dip0`, `dip1`  out  8 each  DIP bytes 0 and 1.
- `core_reset_n`  out  1  active-low reset to `mario_top`.
- `rom_ok`  out  1  the last ROM load was complete and in order.
- `load_err`  out  1  the last ROM load was short or out of order.

## Operation
- States: IDLE (no valid ROM, core held), LOAD, HOLD, RUN.
- After `reset`: IDLE. Output values: `core_reset_n`=0, `rom_ok`=0, `load_err`=0, `dn_wr`=0, `dn_rgn`=0, `dn_addr`=0, `dn_data`=0, `dip0`=`dip1`=8'hFF. Internal state: byte counter 0, hold counter 0.
- Load start: a rising edge of `ioctl_download` with `ioctl_index==ROM_INDEX` enters LOAD from any state.
  - On entry: `core_reset_n`=0, `rom_ok`=0, `load_err`=0, byte counter cleared.
- LOAD, each `ioctl_wr` with `ioctl_addr < RGN_END`:
  - Emit `dn_wr` with the region decode. Region 3 if addr ≥ `RGN3_BASE`, else 2 if addr ≥ `RGN2_BASE`, else 1 if addr ≥ `RGN1_BASE`, else 0.
  - If addr equals the byte counter, increment the counter. Otherwise set `load_err`. The write is still forwarded.
- LOAD, `ioctl_wr` with addr ≥ `RGN_END`: no `dn_wr`, no counter change.
- Load end: a falling edge of `ioctl_download` while in LOAD.
  - If counter == `RGN_END` and `load_err`==0: set `rom_ok`=1, load the hold counter with `HOLD_CYCLES`, go to HOLD.
  - Otherwise: set `load_err`=1, go to IDLE.
- HOLD: `core_reset_n`=0. The hold counter decrements each cycle. At 0, go to RUN.
  - `user_reset` high reloads the counter every cycle.
- RUN: `core_reset_n`=1. `user_reset` high reloads `HOLD_CYCLES` and goes to HOLD.
- IDLE: `user_reset` has no effect. Only a new ROM load leaves IDLE.
- DIP capture, any state: `ioctl_wr` with `ioctl_index==DIP_INDEX` and `ioctl_addr[24:1]==0` writes `dip0` (addr 0) or `dip1` (addr 1). Other DIP addresses are ignored. The FSM is unaffected.
- Downloads with any other index are ignored entirely; no strobes and no state change.
- Simultaneous events:
  - Load-start edge and `user_reset`: the load start wins.
  - Load-start edge while in HOLD or RUN: go directly to LOAD.

## Timing
- `dn_wr`/`dn_rgn`/`dn_addr`/`dn_data` are registered: 1 cycle after the qualifying `ioctl_wr`. `dn_wr` is high for exactly 1 cycle per accepted byte.
- Back-to-back `ioctl_wr` on consecutive cycles must all be forwarded, with no drops.
- `ioctl_download` edges are detected against a 1-cycle registered copy. The state changes 1 cycle after the edge is sampled.
- `core_reset_n` drops in the same cycle the FSM enters LOAD.
- `core_reset_n` rises exactly `HOLD_CYCLES`+1 cycles after HOLD entry, provided `user_reset` stays low.
- `dip0`/`dip1` update 1 cycle after the strobe.
- Asserting `reset` at any point (including mid-load) immediately forces the reset values. Later writes in that load are dropped until a new load-start edge.

## Test plan
- Full in-order load of 0x1A200 bytes, `HOLD_CYCLES`=16 -> exactly 0x1A200 `dn_wr` pulses. `rom_ok`=1, `load_err`=0. `core_reset_n` rises 17 cycles after the download falls.
- Writes at 0x0EFFF, 0x0F000, 0x10000, 0x12000 -> `dn_rgn`/`dn_addr` = 0/EFFF, 1/0000, 2/0000, 3/0000. A write at 0x1A200 produces no `dn_wr`.
- Load stops at 0x100 bytes, or skips address 0x20 -> IDLE, `load_err`=1, `rom_ok`=0, `core_reset_n` stays 0 even while `user_reset` toggles.
- In RUN, `user_reset` high for 5 cycles -> `core_reset_n`=0 during the pulse, then rises `HOLD_CYCLES`+1 cycles after `user_reset` falls.
- DIP download index 254, bytes 0x5A,0x3C,0x77 at addr 0,1,2 -> `dip0`=5A, `dip1`=3C, no `dn_wr`, FSM state unchanged (RUN stays RUN).
- `reset` asserted mid-load at byte 0x800 -> all outputs return to reset values next edge. A subsequent full load behaves as in scenario 1.
